// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider and frame sizing.
// Used by both the transmitter and the receiver on the same serial link.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned clk_div(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return clk_freq / baud;
  endfunction

  function automatic int unsigned frame_bits(
    input int unsigned par_en,
    input int unsigned stop_bits
  );
    return 1 + DATA_BITS + par_en + stop_bits;
  endfunction

  function automatic int unsigned frame_cycles(
    input int unsigned par_en,
    input int unsigned stop_bits,
    input int unsigned div
  );
    return frame_bits(par_en, stop_bits) * div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core handshake and the transmit shifter.
// Depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_data  = mem_q[rd_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as start/8 data/
// optional parity/1-2 stop bits, LSB first, on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CLK_DIV = clk_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW      = $clog2(CLK_DIV);
  localparam int unsigned FCW     = $clog2(FIFO_DEPTH) + 1;

  uart_state_e   state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q, tx_d;
  logic          done_q, busy_q;

  logic [7:0]     fifo_data;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic           tick, stop_end, pop;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_ready = !fifo_full;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

  assign tick     = (baud_q == CW'(CLK_DIV - 1));
  assign stop_end = (state_q == ST_STOP) && tick &&
                    (bit_q == 3'(STOP_BITS - 1));
  // A pop in STOP chains straight into the next START with no idle gap.
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) || stop_end);

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      done_q <= stop_end;
      busy_q <= (state_q != ST_IDLE) || (fifo_count != '0);
      if (pop) begin
        shift_q <= fifo_data;
        par_q   <= (^fifo_data) ^ (PARITY_ODD != 0);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'(DATA_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tick) begin
            baud_q  <= '0;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            baud_q <= '0;
            if (stop_end) begin
              bit_q   <= '0;
              state_q <= pop ? ST_START : ST_IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations at CLK_DIV=10,
// with a behavioural receiver on instance 0 for the loopback check.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] di   [4];
  logic       vi   [4];
  logic       rdy  [4];
  logic       txo  [4];
  logic       busy [4];
  logic       done [4];

  int vecs = 0;
  int errs = 0;

  logic [1023:0] tx_s, done_s, busy_s;
  logic [7:0]    rxq [$];
  int            rx_ferr = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) u0 (
    .i_clk(clk), .i_rst(rst), .i_data(di[0]), .i_valid(vi[0]),
    .o_ready(rdy[0]), .o_tx(txo[0]), .o_busy(busy[0]), .o_done(done[0]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000),
            .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_data(di[1]), .i_valid(vi[1]),
    .o_ready(rdy[1]), .o_tx(txo[1]), .o_busy(busy[1]), .o_done(done[1]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000),
            .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_data(di[2]), .i_valid(vi[2]),
    .o_ready(rdy[2]), .o_tx(txo[2]), .o_busy(busy[2]), .o_done(done[2]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000),
            .STOP_BITS(2)) u3 (
    .i_clk(clk), .i_rst(rst), .i_data(di[3]), .i_valid(vi[3]),
    .o_ready(rdy[3]), .o_tx(txo[3]), .o_busy(busy[3]), .o_done(done[3]));

  // Receiver model: mid-bit sampling, 10 clocks per bit.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (!rst && txo[0] == 1'b0) begin
        repeat (4) @(negedge clk);
        if (txo[0] == 1'b0) begin
          for (int b = 0; b < 8; b++) begin
            repeat (10) @(negedge clk);
            d[b] = txo[0];
          end
          repeat (10) @(negedge clk);
          if (txo[0] == 1'b1) rxq.push_back(d);
          else rx_ferr++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [7:0] b);
    @(negedge clk);
    di[k] = b;
    vi[k] = 1'b1;
    @(negedge clk);
    vi[k] = 1'b0;
  endtask

  // Records n samples starting at the current negedge.
  task automatic capture(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      tx_s[c]   = txo[k];
      done_s[c] = done[k];
      busy_s[c] = busy[k];
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if ({txo[k], rdy[k], busy[k], done[k]} !== 4'b1100) begin
        errs++;
        $display("FAIL reset u%0d: tx/rdy/busy/done=%b%b%b%b want 1100",
                 k, txo[k], rdy[k], busy[k], done[k]);
      end
    end
  endtask

  task automatic test_basic;
    logic [11:0] fr;
    logic        e;
    fr = 12'b00_1_01010101_0;
    push(0, 8'h55);
    capture(0, 104);
    for (int c = 0; c < 104; c++) begin
      e = (c >= 2 && c < 102) ? fr[(c - 2) / 10] : 1'b1;
      vecs++;
      if (tx_s[c] !== e) begin
        errs++;
        $display("FAIL basic tx c=%0d got %b want %b", c, tx_s[c], e);
      end
      vecs++;
      if (done_s[c] !== (c == 101)) begin
        errs++;
        $display("FAIL basic done c=%0d got %b want %b",
                 c, done_s[c], c == 101);
      end
      vecs++;
      if (busy_s[c] !== (c >= 1 && c <= 101)) begin
        errs++;
        $display("FAIL basic busy c=%0d got %b want %b",
                 c, busy_s[c], c >= 1 && c <= 101);
      end
    end
  endtask

  task automatic test_parity;
    logic [11:0] fr;
    logic        e;
    for (int k = 1; k <= 2; k++) begin
      fr = (k == 1) ? 12'b0_1_1_00000111_0 : 12'b0_1_0_00000111_0;
      push(k, 8'h07);
      capture(k, 114);
      for (int c = 0; c < 114; c++) begin
        e = (c >= 2 && c < 112) ? fr[(c - 2) / 10] : 1'b1;
        vecs++;
        if (tx_s[c] !== e) begin
          errs++;
          $display("FAIL parity u%0d tx c=%0d got %b want %b",
                   k, c, tx_s[c], e);
        end
        vecs++;
        if (done_s[c] !== (c == 111)) begin
          errs++;
          $display("FAIL parity u%0d done c=%0d got %b want %b",
                   k, c, done_s[c], c == 111);
        end
      end
    end
  endtask

  task automatic test_two_stop;
    logic [11:0] fr;
    logic        e;
    fr = 12'b0_1_1_10100011_0;
    push(3, 8'hA3);
    capture(3, 114);
    for (int c = 0; c < 114; c++) begin
      e = (c >= 2 && c < 112) ? fr[(c - 2) / 10] : 1'b1;
      vecs++;
      if (tx_s[c] !== e) begin
        errs++;
        $display("FAIL stop2 tx c=%0d got %b want %b", c, tx_s[c], e);
      end
      vecs++;
      if (done_s[c] !== (c == 111)) begin
        errs++;
        $display("FAIL stop2 done c=%0d got %b want %b",
                 c, done_s[c], c == 111);
      end
      vecs++;
      if (busy_s[c] !== (c >= 1 && c <= 111)) begin
        errs++;
        $display("FAIL stop2 busy c=%0d got %b want %b",
                 c, busy_s[c], c >= 1 && c <= 111);
      end
    end
  endtask

  task automatic test_back_to_back;
    int         acc [7];
    int         i;
    int         want_acc [7];
    logic       r;
    logic       seen_full;
    logic       e;
    logic [9:0] fr;
    want_acc = '{0, 0, 1, 2, 3, 4, 102};
    acc = '{default: -1};
    seen_full = 1'b0;
    @(negedge clk);
    i = 1;
    di[0] = 8'h01;
    vi[0] = 1'b1;
    r = rdy[0];
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (vi[0] && r) begin
        acc[i] = c;
        i++;
        if (i <= 6) di[0] = 8'(i);
        else vi[0] = 1'b0;
      end
      r = rdy[0];
      if (vi[0] && i == 6 && !seen_full) begin
        seen_full = 1'b1;
        vecs++;
        if (r !== 1'b0) begin
          errs++;
          $display("FAIL b2b ready_full c=%0d got %b want 0", c, r);
        end
      end
      tx_s[c]   = txo[0];
      done_s[c] = done[0];
      busy_s[c] = busy[0];
    end
    for (int j = 1; j <= 6; j++) begin
      vecs++;
      if (acc[j] !== want_acc[j]) begin
        errs++;
        $display("FAIL b2b accept byte%0d got c=%0d want c=%0d",
                 j, acc[j], want_acc[j]);
      end
    end
    for (int c = 0; c < 700; c++) begin
      e = (c >= 101 && c <= 601 && (c - 101) % 100 == 0);
      vecs++;
      if (done_s[c] !== e) begin
        errs++;
        $display("FAIL b2b done c=%0d got %b want %b", c, done_s[c], e);
      end
    end
    for (int j = 0; j < 6; j++) begin
      fr = {1'b1, 8'(j + 1), 1'b0};
      for (int b = 0; b < 10; b++) begin
        vecs++;
        if (tx_s[2 + 100 * j + 10 * b + 5] !== fr[b]) begin
          errs++;
          $display("FAIL b2b frame%0d bit%0d got %b want %b",
                   j, b, tx_s[2 + 100 * j + 10 * b + 5], fr[b]);
        end
      end
    end
    vecs++;
    if ({busy_s[601], busy_s[602]} !== 2'b10) begin
      errs++;
      $display("FAIL b2b busy_end got %b want 10",
               {busy_s[601], busy_s[602]});
    end
  endtask

  task automatic test_loopback;
    logic [7:0] want [3];
    int         t;
    want = '{8'h00, 8'hFF, 8'h3C};
    rxq.delete();
    rx_ferr = 0;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    t = 0;
    while (rxq.size() < 3 && t < 600) begin
      @(negedge clk);
      t++;
    end
    vecs++;
    if (rxq.size() != 3 || rx_ferr != 0) begin
      errs++;
      $display("FAIL loopback count got %0d frames (%0d bad) want 3",
               rxq.size(), rx_ferr);
    end
    for (int j = 0; j < 3; j++) begin
      vecs++;
      if (j >= rxq.size() || rxq[j] !== want[j]) begin
        errs++;
        $display("FAIL loopback byte%0d got %h want %h", j,
                 (j < rxq.size()) ? rxq[j] : 8'hxx, want[j]);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int bad_tx, bad_done, bad_busy;
    push(0, 8'hF0);
    push(0, 8'h11);
    push(0, 8'h22);
    repeat (41) @(negedge clk);
    vecs++;
    if ({txo[0], busy[0]} !== 2'b01) begin
      errs++;
      $display("FAIL rstmid pre tx/busy got %b%b want 01", txo[0], busy[0]);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({txo[0], rdy[0], busy[0], done[0]} !== 4'b1100) begin
      errs++;
      $display("FAIL rstmid async tx/rdy/busy/done got %b%b%b%b want 1100",
               txo[0], rdy[0], busy[0], done[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad_tx = 0;
    bad_done = 0;
    bad_busy = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (txo[0] !== 1'b1) bad_tx++;
      if (done[0] !== 1'b0) bad_done++;
      if (busy[0] !== 1'b0) bad_busy++;
    end
    vecs++;
    if (bad_tx != 0) begin
      errs++;
      $display("FAIL rstmid idle tx low %0d cycles want 0", bad_tx);
    end
    vecs++;
    if (bad_done != 0) begin
      errs++;
      $display("FAIL rstmid done high %0d cycles want 0", bad_done);
    end
    vecs++;
    if (bad_busy != 0) begin
      errs++;
      $display("FAIL rstmid busy high %0d cycles want 0", bad_busy);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      di[k] = 8'h00;
      vi[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_two_stop;
    test_back_to_back;
    repeat (20) @(negedge clk);
    test_loopback;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
